// File: rtl/parking_gate_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : parking_gate_arbiter
// Brief    : Shared-lane gate controller. Arbitrates entry/exit requests,
//            tracks the car through beams a/b and keeps the occupancy count.
//            Optional statistics counters are enabled by GATE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module parking_gate_arbiter #(
    parameter int OCC_W          = 4,
    parameter int CAPACITY       = 15,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             a,
    input  logic             b,
    output logic             gate_open,
    output logic             entry_grant,
    output logic             exit_grant,
    output logic [OCC_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             car_in,
    output logic             car_out,
    output logic             timeout
`ifdef GATE_STATS_EN
    ,
    output logic [7:0]       rejected_cnt,
    output logic [7:0]       timeout_cnt
`endif
);

    localparam int                 c_tmr_w    = $clog2(TIMEOUT_CYCLES);
    localparam logic [OCC_W-1:0]   c_cap      = OCC_W'(CAPACITY);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT_CYCLES - 1);

    // Bit 3 marks the exit lane so lane ownership decodes from the state alone.
    localparam logic [3:0] c_idle   = 4'b0000;
    localparam logic [3:0] c_g_in   = 4'b0001;
    localparam logic [3:0] c_in_a   = 4'b0010;
    localparam logic [3:0] c_in_ab  = 4'b0011;
    localparam logic [3:0] c_in_b   = 4'b0100;
    localparam logic [3:0] c_g_out  = 4'b1001;
    localparam logic [3:0] c_out_b  = 4'b1010;
    localparam logic [3:0] c_out_ba = 4'b1011;
    localparam logic [3:0] c_out_a  = 4'b1100;

    logic [3:0]         r_state, w_state_nxt;
    logic [c_tmr_w-1:0] r_timer, w_timer_nxt;
    logic [OCC_W-1:0]   r_occ, w_occ_nxt;
    logic               r_last_exit;
    logic               r_full, r_empty, r_gate_open, r_entry_grant, r_exit_grant;
    logic               r_car_in, r_car_out, r_timeout;
    logic               w_pass_in, w_pass_out, w_tmo, w_ent_v, w_ext_v;
    logic [1:0]         w_ab;

    assign w_ent_v = entry_req & ~r_full;
    assign w_ext_v = exit_req & ~r_empty;
    assign w_ab    = {a, b};

    always_comb begin
        w_state_nxt = r_state;
        w_pass_in   = 1'b0;
        w_pass_out  = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            c_idle: begin
                if (w_ent_v && (!w_ext_v || r_last_exit)) w_state_nxt = c_g_in;
                else if (w_ext_v)                         w_state_nxt = c_g_out;
            end
            c_g_in: begin
                if (w_ab == 2'b10) w_state_nxt = c_in_a;
                else if (r_timer == c_tmr_last) begin
                    w_state_nxt = c_idle;
                    w_tmo       = 1'b1;
                end
            end
            c_in_a: begin
                if (w_ab == 2'b11)      w_state_nxt = c_in_ab;
                else if (w_ab == 2'b00) w_state_nxt = c_g_in;
            end
            c_in_ab: begin
                if (w_ab == 2'b01)      w_state_nxt = c_in_b;
                else if (w_ab == 2'b10) w_state_nxt = c_in_a;
            end
            c_in_b: begin
                if (w_ab == 2'b00) begin
                    w_state_nxt = c_idle;
                    w_pass_in   = 1'b1;
                end else if (w_ab == 2'b11) w_state_nxt = c_in_ab;
            end
            c_g_out: begin
                if (w_ab == 2'b01) w_state_nxt = c_out_b;
                else if (r_timer == c_tmr_last) begin
                    w_state_nxt = c_idle;
                    w_tmo       = 1'b1;
                end
            end
            c_out_b: begin
                if (w_ab == 2'b11)      w_state_nxt = c_out_ba;
                else if (w_ab == 2'b00) w_state_nxt = c_g_out;
            end
            c_out_ba: begin
                if (w_ab == 2'b10)      w_state_nxt = c_out_a;
                else if (w_ab == 2'b01) w_state_nxt = c_out_b;
            end
            c_out_a: begin
                if (w_ab == 2'b00) begin
                    w_state_nxt = c_idle;
                    w_pass_out  = 1'b1;
                end else if (w_ab == 2'b11) w_state_nxt = c_out_ba;
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    // Timer only accumulates while parked in a grant state; any entry into one clears it.
    always_comb begin
        w_timer_nxt = '0;
        if ((w_state_nxt == r_state) && ((r_state == c_g_in) || (r_state == c_g_out)))
            w_timer_nxt = r_timer + 1'b1;
    end

    always_comb begin
        w_occ_nxt = r_occ;
        if (w_pass_in && (r_occ != c_cap))
            w_occ_nxt = r_occ + 1'b1;
        else if (w_pass_out && (r_occ != '0))
            w_occ_nxt = r_occ - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_idle;
            r_timer       <= '0;
            r_occ         <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_last_exit   <= 1'b1;
            r_gate_open   <= 1'b0;
            r_entry_grant <= 1'b0;
            r_exit_grant  <= 1'b0;
            r_car_in      <= 1'b0;
            r_car_out     <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_occ         <= w_occ_nxt;
            r_full        <= (w_occ_nxt == c_cap);
            r_empty       <= (w_occ_nxt == '0);
            r_gate_open   <= (w_state_nxt != c_idle);
            r_entry_grant <= (w_state_nxt != c_idle) && !w_state_nxt[3];
            r_exit_grant  <= w_state_nxt[3];
            r_car_in      <= w_pass_in;
            r_car_out     <= w_pass_out;
            r_timeout     <= w_tmo;
            if (r_state == c_idle && w_state_nxt == c_g_in)
                r_last_exit <= 1'b0;
            else if (r_state == c_idle && w_state_nxt == c_g_out)
                r_last_exit <= 1'b1;
        end
    end

    assign gate_open   = r_gate_open;
    assign entry_grant = r_entry_grant;
    assign exit_grant  = r_exit_grant;
    assign occupancy   = r_occ;
    assign full        = r_full;
    assign empty       = r_empty;
    assign car_in      = r_car_in;
    assign car_out     = r_car_out;
    assign timeout     = r_timeout;

`ifdef GATE_STATS_EN
    logic       r_entry_req_d;
    logic [7:0] r_rej_cnt, r_tmo_cnt;

    // A held request while full counts once, on its rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_entry_req_d <= 1'b0;
            r_rej_cnt     <= '0;
            r_tmo_cnt     <= '0;
        end else begin
            r_entry_req_d <= entry_req;
            if ((r_state == c_idle) && entry_req && !r_entry_req_d && r_full && (r_rej_cnt != 8'hff))
                r_rej_cnt <= r_rej_cnt + 1'b1;
            if (w_tmo && (r_tmo_cnt != 8'hff))
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign rejected_cnt = r_rej_cnt;
    assign timeout_cnt  = r_tmo_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_parking_gate_arbiter
// Brief    : Directed self-checking bench with a pulse scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parking_gate_arbiter;

    logic       clk;
    logic       reset;
    logic       entry_req;
    logic       exit_req;
    logic       a;
    logic       b;
    logic       gate_open;
    logic       entry_grant;
    logic       exit_grant;
    logic [3:0] occupancy;
    logic       full;
    logic       empty;
    logic       car_in;
    logic       car_out;
    logic       timeout;
`ifdef GATE_STATS_EN
    logic [7:0] rejected_cnt;
    logic [7:0] timeout_cnt;
`endif

    parking_gate_arbiter #(
        .OCC_W         (4),
        .CAPACITY      (15),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .entry_req   (entry_req),
        .exit_req    (exit_req),
        .a           (a),
        .b           (b),
        .gate_open   (gate_open),
        .entry_grant (entry_grant),
        .exit_grant  (exit_grant),
        .occupancy   (occupancy),
        .full        (full),
        .empty       (empty),
        .car_in      (car_in),
        .car_out     (car_out),
        .timeout     (timeout)
`ifdef GATE_STATS_EN
        ,
        .rejected_cnt(rejected_cnt),
        .timeout_cnt (timeout_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] kind;   // {car_in, car_out, timeout}
        logic [3:0] occ;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_occ = 4'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_seq(input logic [1:0] s0, input logic [1:0] s1,
                           input logic [1:0] s2, input logic [1:0] s3);
        {a, b} = s0; hold(10);
        {a, b} = s1; hold(10);
        {a, b} = s2; hold(10);
        {a, b} = s3; hold(1);
    endtask

    task automatic do_entry();
        entry_req = 1'b1;
        hold(1);
        chk("entry_grant", entry_grant, 1);
        chk("entry_gate_open", gate_open, 1);
        entry_req = 1'b0;
        exp_occ++;
        sb.push_back('{3'b100, exp_occ});
        run_seq(2'b10, 2'b11, 2'b01, 2'b00);
        chk("entry_car_in", car_in, 1);
        hold(2);
        chk("entry_occ", occupancy, exp_occ);
        chk("entry_gate_closed", gate_open, 0);
    endtask

    task automatic do_exit();
        exit_req = 1'b1;
        hold(1);
        chk("exit_grant", exit_grant, 1);
        exit_req = 1'b0;
        exp_occ--;
        sb.push_back('{3'b010, exp_occ});
        run_seq(2'b01, 2'b11, 2'b10, 2'b00);
        chk("exit_car_out", car_out, 1);
        hold(2);
        chk("exit_occ", occupancy, exp_occ);
    endtask

    // Every completion or timeout pulse must match the next expected event.
    always @(negedge clk) begin
        if (!reset && (car_in || car_out || timeout)) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_pulse", {29'd0, car_in, car_out, timeout}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_kind", {29'd0, car_in, car_out, timeout}, {29'd0, e.kind});
                chk("sb_occ", occupancy, e.occ);
            end
        end
    end

    initial begin
        reset = 1'b1; entry_req = 1'b0; exit_req = 1'b0; a = 1'b0; b = 1'b0;
        hold(3);
        chk("rst_gate_open", gate_open, 0);
        chk("rst_grants", {entry_grant, exit_grant}, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_pulses", {car_in, car_out, timeout}, 0);
        reset = 1'b0;
        hold(2);

        // Exit blocked while empty
        exit_req = 1'b1;
        hold(3);
        chk("empty_no_exit_grant", exit_grant, 0);
        exit_req = 1'b0;
        hold(1);

        do_entry();
        chk("empty_after_entry", empty, 0);
        do_exit();
        chk("empty_after_exit", empty, 1);

        // Grant left unused expires after TIMEOUT_CYCLES
        entry_req = 1'b1;
        hold(1);
        chk("tmo_grant", entry_grant, 1);
        entry_req = 1'b0;
        sb.push_back('{3'b001, exp_occ});
        hold(63);
        chk("tmo_not_yet", timeout, 0);
        chk("tmo_gate_still_open", gate_open, 1);
        hold(1);
        chk("tmo_pulse", timeout, 1);
        chk("tmo_gate_closed", gate_open, 0);
        chk("tmo_occ", occupancy, exp_occ);
`ifdef GATE_STATS_EN
        chk("tmo_cnt", timeout_cnt, 1);
`endif
        hold(2);

        // Reach 3 with last served = exit, then a tie goes to entry
        repeat (4) do_entry();
        do_exit();
        entry_req = 1'b1; exit_req = 1'b1;
        hold(1);
        chk("tie_entry_first", {entry_grant, exit_grant}, 2'b10);
        exp_occ++;
        sb.push_back('{3'b100, exp_occ});
        run_seq(2'b10, 2'b11, 2'b01, 2'b00);
        chk("tie_car_in", car_in, 1);
        chk("tie_no_grant_on_complete", {entry_grant, exit_grant}, 2'b00);
        hold(1);
        chk("tie_alternates_exit", {entry_grant, exit_grant}, 2'b01);
        entry_req = 1'b0; exit_req = 1'b0;
        exp_occ--;
        sb.push_back('{3'b010, exp_occ});
        run_seq(2'b01, 2'b11, 2'b10, 2'b00);
        hold(2);
        chk("tie_occ", occupancy, 3);

        // Wrong-direction pattern ignored, back-out returns to grant, then pass
        entry_req = 1'b1;
        hold(1);
        entry_req = 1'b0;
        {a, b} = 2'b01; hold(5);
        chk("ignored_pattern_gate", gate_open, 1);
        {a, b} = 2'b10; hold(5);
        {a, b} = 2'b00; hold(5);
        chk("backout_no_count", occupancy, 3);
        chk("backout_still_granted", entry_grant, 1);
        exp_occ++;
        sb.push_back('{3'b100, exp_occ});
        run_seq(2'b10, 2'b11, 2'b01, 2'b00);
        hold(2);
        chk("backout_then_pass_occ", occupancy, 4);

        // Fill to capacity, entry then blocked
        repeat (11) do_entry();
        chk("full_flag", full, 1);
        chk("full_occ", occupancy, 15);
        entry_req = 1'b1;
        hold(4);
        chk("full_no_grant", {entry_grant, gate_open}, 2'b00);
`ifdef GATE_STATS_EN
        chk("rejected_cnt", rejected_cnt, 1);
`endif
        entry_req = 1'b0;
        hold(1);

        // Reset in the middle of an entry pass aborts it
        do_exit();
        entry_req = 1'b1;
        hold(1);
        entry_req = 1'b0;
        {a, b} = 2'b10; hold(3);
        {a, b} = 2'b11; hold(3);
        reset = 1'b1;
        hold(1);
        reset = 1'b0;
        exp_occ = 4'd0;
        chk("midrst_gate", gate_open, 0);
        chk("midrst_occ", occupancy, 0);
        chk("midrst_grant", entry_grant, 0);
        chk("midrst_car_in", car_in, 0);
        {a, b} = 2'b01; hold(3);
        {a, b} = 2'b00; hold(5);
        chk("midrst_no_count", occupancy, 0);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
